// File: rtl/axis_reduce_pe.sv
// Mesh endpoint that gathers one operand per source slot and reduces them.
// The reduction runs one combine per cycle, and each set sends one result to a fixed destination.
module axis_reduce_pe #(
    parameter int TDATAW       = 32,
    parameter int TDESTW       = 4,
    parameter int TIDW         = 2,
    parameter int NUM_OPERANDS = 2,
    parameter int OP_MODE      = 0,
    parameter int SATURATE     = 0,
    parameter int DEST_ADDR    = 3
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              AXIS_S_TVALID,
    output logic              AXIS_S_TREADY,
    input  logic [TDATAW-1:0] AXIS_S_TDATA,
    input  logic              AXIS_S_TLAST,
    input  logic [TIDW-1:0]   AXIS_S_TID,
    input  logic [TDESTW-1:0] AXIS_S_TDEST,
    output logic              AXIS_M_TVALID,
    input  logic              AXIS_M_TREADY,
    output logic [TDATAW-1:0] AXIS_M_TDATA,
    output logic              AXIS_M_TLAST,
    output logic [TDESTW-1:0] AXIS_M_TDEST,
    output logic [15:0]       RESULT_CNT,
    output logic [15:0]       DROP_CNT,
    output logic              OVF
);

    localparam logic [TIDW:0]   NUM_OPS  = (TIDW+1)'(NUM_OPERANDS);
    localparam logic [TIDW-1:0] LAST_IDX = TIDW'(NUM_OPERANDS - 1);

    typedef enum logic [1:0] {
        COLLECT,
        REDUCE,
        SEND
    } state_t;

    state_t state, state_next;

    logic [TDATAW-1:0]       slot [NUM_OPERANDS];
    logic [NUM_OPERANDS-1:0] filled, filled_next;
    logic [TIDW-1:0]         idx;
    logic [TDATAW-1:0]       acc, cur_slot, combined;
    logic [TDATAW:0]         sum;
    logic                    ovf_flag, carry;
    logic                    in_range, slot_busy, s_hs, m_hs, set_done;
    logic                    unused_ok;

    assign unused_ok = ^{AXIS_S_TLAST, AXIS_S_TDEST};

    // Slot lookup, input handshake and set completion
    always_comb begin
        in_range    = {1'b0, AXIS_S_TID} < NUM_OPS;
        slot_busy   = 1'b0;
        filled_next = filled;
        for (int i = 0; i < NUM_OPERANDS; i++) begin
            if (AXIS_S_TID == TIDW'(i)) slot_busy = filled[i];
        end
        AXIS_S_TREADY = (state == COLLECT) && (!in_range || !slot_busy);
        s_hs          = AXIS_S_TVALID && AXIS_S_TREADY;
        for (int i = 0; i < NUM_OPERANDS; i++) begin
            if (s_hs && AXIS_S_TID == TIDW'(i)) filled_next[i] = 1'b1;
        end
        set_done = s_hs && in_range && (&filled_next);
        m_hs     = (state == SEND) && AXIS_M_TREADY;
    end

    always_comb begin
        cur_slot = '0;
        for (int i = 0; i < NUM_OPERANDS; i++) begin
            if (idx == TIDW'(i)) cur_slot = slot[i];
        end
        sum      = {1'b0, acc} + {1'b0, cur_slot};
        carry    = 1'b0;
        combined = sum[TDATAW-1:0];
        case (OP_MODE)
            0: begin
                carry = sum[TDATAW];
                if (SATURATE != 0 && carry) combined = '1;
            end
            1:       combined = (cur_slot > acc) ? cur_slot : acc;
            2:       combined = (cur_slot < acc) ? cur_slot : acc;
            default: combined = acc ^ cur_slot;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            COLLECT: if (set_done) state_next = REDUCE;
            REDUCE:  if (idx == LAST_IDX) state_next = SEND;
            SEND:    if (AXIS_M_TREADY) state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= COLLECT;
        else        state <= state_next;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            filled <= '0;
            for (int i = 0; i < NUM_OPERANDS; i++) slot[i] <= '0;
        end else begin
            filled <= m_hs ? '0 : filled_next;
            for (int i = 0; i < NUM_OPERANDS; i++) begin
                if (s_hs && AXIS_S_TID == TIDW'(i)) slot[i] <= AXIS_S_TDATA;
            end
        end
    end

    // Step 0 seeds acc from slot 0, steps 1..N-1 fold in one slot each
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            idx      <= '0;
            acc      <= '0;
            ovf_flag <= 1'b0;
        end else if (state == REDUCE) begin
            if (idx == '0) begin
                acc      <= slot[0];
                ovf_flag <= 1'b0;
            end else begin
                acc      <= combined;
                ovf_flag <= ovf_flag | carry;
            end
            idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            RESULT_CNT <= '0;
            DROP_CNT   <= '0;
        end else begin
            if (m_hs && RESULT_CNT != 16'hFFFF) RESULT_CNT <= RESULT_CNT + 16'd1;
            if (s_hs && !in_range && DROP_CNT != 16'hFFFF) DROP_CNT <= DROP_CNT + 16'd1;
        end
    end

    assign AXIS_M_TVALID = (state == SEND);
    assign AXIS_M_TDATA  = (state == SEND) ? acc : '0;
    assign AXIS_M_TLAST  = (state == SEND);
    assign AXIS_M_TDEST  = (state == SEND) ? TDESTW'(DEST_ADDR) : '0;
    assign OVF           = (state == SEND) && ovf_flag;

endmodule

// File: tb/tb_axis_reduce_pe.sv
// Scoreboard bench: a 32-bit add/N=2 node for handshake, counter and reset behaviour,
// plus five 8-bit nodes covering wrap/saturating add, max, min and xor reductions.
module tb_axis_reduce_pe;

    logic        clk, rst_n;
    logic        s_tvalid, s_tready, s_tlast;
    logic [31:0] s_tdata;
    logic [1:0]  s_tid;
    logic [3:0]  s_tdest;
    logic        m_tvalid, m_tready, m_tlast, ovf;
    logic [31:0] m_tdata;
    logic [3:0]  m_tdest;
    logic [15:0] result_cnt, drop_cnt;

    logic        aux_s_tvalid [5];
    logic        aux_s_tready [5];
    logic [1:0]  aux_s_tid    [5];
    logic [7:0]  aux_s_tdata  [5];
    logic        aux_m_tvalid [5];
    logic [7:0]  aux_m_tdata  [5];
    logic        aux_m_tlast  [5];
    logic [3:0]  aux_m_tdest  [5];
    logic        aux_ovf      [5];
    logic [15:0] aux_rcnt     [5];
    logic [15:0] aux_dcnt     [5];

    typedef struct packed {logic [31:0] data; logic ovf;} main_exp_t;
    typedef struct packed {logic [2:0] k; logic [7:0] data; logic ovf;} aux_exp_t;
    main_exp_t main_q[$];
    aux_exp_t  aux_q[$];
    main_exp_t mon_e;
    aux_exp_t  mon_a;

    int checks = 0;
    int failures = 0;

    axis_reduce_pe u_main (
        .CLK(clk), .RST_N(rst_n),
        .AXIS_S_TVALID(s_tvalid), .AXIS_S_TREADY(s_tready), .AXIS_S_TDATA(s_tdata),
        .AXIS_S_TLAST(s_tlast), .AXIS_S_TID(s_tid), .AXIS_S_TDEST(s_tdest),
        .AXIS_M_TVALID(m_tvalid), .AXIS_M_TREADY(m_tready), .AXIS_M_TDATA(m_tdata),
        .AXIS_M_TLAST(m_tlast), .AXIS_M_TDEST(m_tdest),
        .RESULT_CNT(result_cnt), .DROP_CNT(drop_cnt), .OVF(ovf)
    );

    // Instance 0: wrapping add N=4, 1: saturating add N=4, 2: max N=3, 3: min N=3, 4: xor N=3
    for (genvar g = 0; g < 5; g++) begin : g_aux
        axis_reduce_pe #(
            .TDATAW(8), .NUM_OPERANDS((g < 2) ? 4 : 3),
            .OP_MODE((g < 2) ? 0 : g - 1), .SATURATE((g == 1) ? 1 : 0)
        ) u_aux (
            .CLK(clk), .RST_N(rst_n),
            .AXIS_S_TVALID(aux_s_tvalid[g]), .AXIS_S_TREADY(aux_s_tready[g]),
            .AXIS_S_TDATA(aux_s_tdata[g]), .AXIS_S_TLAST(1'b1),
            .AXIS_S_TID(aux_s_tid[g]), .AXIS_S_TDEST(4'd0),
            .AXIS_M_TVALID(aux_m_tvalid[g]), .AXIS_M_TREADY(1'b1),
            .AXIS_M_TDATA(aux_m_tdata[g]), .AXIS_M_TLAST(aux_m_tlast[g]),
            .AXIS_M_TDEST(aux_m_tdest[g]),
            .RESULT_CNT(aux_rcnt[g]), .DROP_CNT(aux_dcnt[g]), .OVF(aux_ovf[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one operand and hold it until the DUT takes it (bounded)
    task automatic applyStimulus(input logic [1:0] tid, input logic [31:0] data);
        int n;
        s_tvalid = 1'b1;
        s_tid    = tid;
        s_tdata  = data;
        n = 0;
        @(negedge clk);
        while (!s_tready && n < 30) begin
            @(negedge clk);
            n++;
        end
        checkOutput("s_accept", s_tready, 1);
        @(posedge clk);
        #1 s_tvalid = 1'b0;
    endtask

    task automatic send_aux(input int k, input logic [1:0] tid, input logic [7:0] data);
        int n;
        aux_s_tvalid[k] = 1'b1;
        aux_s_tid[k]    = tid;
        aux_s_tdata[k]  = data;
        n = 0;
        @(negedge clk);
        while (!aux_s_tready[k] && n < 30) begin
            @(negedge clk);
            n++;
        end
        checkOutput("aux_s_accept", aux_s_tready[k], 1);
        @(posedge clk);
        #1 aux_s_tvalid[k] = 1'b0;
    endtask

    task automatic run_aux(input int k, input int n, input logic [7:0] o0, input logic [7:0] o1,
                           input logic [7:0] o2, input logic [7:0] o3,
                           input logic [7:0] res, input logic ov);
        logic [7:0] ops [4];
        ops[0] = o0; ops[1] = o1; ops[2] = o2; ops[3] = o3;
        aux_q.push_back({3'(k), res, ov});
        for (int t = n - 1; t >= 0; t--) send_aux(k, 2'(t), ops[t]);
        idle(n + 4);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!m_tvalid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic check_reset_state();
        checkOutput("rst_m_tvalid", m_tvalid, 0);
        checkOutput("rst_m_tdata", m_tdata, 0);
        checkOutput("rst_m_tlast", m_tlast, 0);
        checkOutput("rst_m_tdest", m_tdest, 0);
        checkOutput("rst_ovf", ovf, 0);
        checkOutput("rst_result_cnt", result_cnt, 0);
        checkOutput("rst_drop_cnt", drop_cnt, 0);
        checkOutput("rst_s_tready", s_tready, 1);
    endtask

    always @(negedge clk) begin
        if (rst_n && m_tvalid && m_tready) begin
            if (main_q.size() == 0) begin
                checkOutput("main_q_nonempty", main_q.size(), 1);
            end else begin
                mon_e = main_q.pop_front();
                checkOutput("m_tdata", m_tdata, mon_e.data);
                checkOutput("m_ovf", ovf, mon_e.ovf);
                checkOutput("m_tlast", m_tlast, 1);
                checkOutput("m_tdest", m_tdest, 3);
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 5; k++) begin
            if (rst_n && aux_m_tvalid[k]) begin
                if (aux_q.size() == 0) begin
                    checkOutput("aux_q_nonempty", aux_q.size(), 1);
                end else begin
                    mon_a = aux_q.pop_front();
                    checkOutput("aux_inst", k, mon_a.k);
                    checkOutput("aux_tdata", aux_m_tdata[k], mon_a.data);
                    checkOutput("aux_ovf", aux_ovf[k], mon_a.ovf);
                    checkOutput("aux_tlast", aux_m_tlast[k], 1);
                    checkOutput("aux_tdest", aux_m_tdest[k], 3);
                end
            end
        end
    end

    initial begin
        int lat;
        rst_n = 1'b0;
        s_tvalid = 1'b0; s_tlast = 1'b1; s_tid = '0; s_tdata = '0; s_tdest = '0;
        m_tready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            aux_s_tvalid[k] = 1'b0; aux_s_tid[k] = '0; aux_s_tdata[k] = '0;
        end
        #2 check_reset_state();
        idle(2);
        rst_n = 1'b1;

        // Add N=2 with latency measurement
        main_q.push_back({32'd12, 1'b0});
        applyStimulus(2'd1, 32'd5);
        applyStimulus(2'd0, 32'd7);
        wait_valid(lat);
        checkOutput("latency", lat, 2);
        idle(3);
        checkOutput("result_cnt_1", result_cnt, 1);

        main_q.push_back({32'd1, 1'b1});
        applyStimulus(2'd0, 32'hFFFF_FFFF);
        applyStimulus(2'd1, 32'd2);
        idle(5);
        checkOutput("result_cnt_2", result_cnt, 2);

        // Duplicate slot stalls, out-of-range slot is dropped
        main_q.push_back({32'd5, 1'b0});
        main_q.push_back({32'd8, 1'b0});
        applyStimulus(2'd0, 32'd1);
        s_tvalid = 1'b1; s_tid = 2'd0; s_tdata = 32'd2;
        repeat (3) begin
            @(negedge clk);
            checkOutput("dup_stall", s_tready, 0);
        end
        @(posedge clk);
        #1 s_tvalid = 1'b0;
        applyStimulus(2'd3, 32'd9);
        checkOutput("drop_cnt", drop_cnt, 1);
        applyStimulus(2'd1, 32'd4);
        applyStimulus(2'd0, 32'd2);
        checkOutput("dup_after_result", result_cnt, 3);
        applyStimulus(2'd1, 32'd6);
        idle(5);
        checkOutput("result_cnt_4", result_cnt, 4);
        checkOutput("drop_cnt_hold", drop_cnt, 1);

        // Backpressure: outputs hold while the mesh is not ready
        m_tready = 1'b0;
        main_q.push_back({32'd30, 1'b0});
        applyStimulus(2'd0, 32'd10);
        applyStimulus(2'd1, 32'd20);
        wait_valid(lat);
        checkOutput("bp_latency", lat, 2);
        repeat (10) begin
            @(negedge clk);
            checkOutput("bp_tvalid", m_tvalid, 1);
            checkOutput("bp_tdata", m_tdata, 30);
            checkOutput("bp_tlast", m_tlast, 1);
            checkOutput("bp_tdest", m_tdest, 3);
            checkOutput("bp_ovf", ovf, 0);
            checkOutput("bp_s_tready", s_tready, 0);
            checkOutput("bp_result_cnt", result_cnt, 4);
        end
        @(posedge clk);
        #1 m_tready = 1'b1;
        idle(4);
        checkOutput("bp_result_once", result_cnt, 5);

        // Reset while reducing
        applyStimulus(2'd0, 32'd1);
        applyStimulus(2'd1, 32'd2);
        rst_n = 1'b0;
        #1 check_reset_state();
        idle(2);
        rst_n = 1'b1;
        idle(6);
        checkOutput("rst_no_pending", m_tvalid, 0);
        checkOutput("rst_cnt_held", result_cnt, 0);

        // Reset while a result is pending
        m_tready = 1'b0;
        applyStimulus(2'd0, 32'd50);
        applyStimulus(2'd1, 32'd60);
        wait_valid(lat);
        checkOutput("pre_rst_valid", m_tvalid, 1);
        rst_n = 1'b0;
        #1 check_reset_state();
        idle(2);
        rst_n = 1'b1;
        m_tready = 1'b1;
        main_q.push_back({32'd123, 1'b0});
        applyStimulus(2'd0, 32'd100);
        applyStimulus(2'd1, 32'd23);
        idle(6);
        checkOutput("post_rst_result_cnt", result_cnt, 1);
        checkOutput("post_rst_drop_cnt", drop_cnt, 0);

        // 8-bit operator variants
        run_aux(0, 4, 8'hF0, 8'h20, 8'h01, 8'h02, 8'h13, 1'b1);
        run_aux(0, 4, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A, 1'b0);
        run_aux(1, 4, 8'hF0, 8'h20, 8'h01, 8'h02, 8'hFF, 1'b1);
        run_aux(1, 4, 8'h10, 8'h20, 8'h30, 8'h40, 8'hA0, 1'b0);
        run_aux(2, 3, 8'd9, 8'd40, 8'd17, 8'h00, 8'd40, 1'b0);
        run_aux(2, 3, 8'd200, 8'd5, 8'd100, 8'h00, 8'd200, 1'b0);
        run_aux(3, 3, 8'd9, 8'd40, 8'd17, 8'h00, 8'd9, 1'b0);
        run_aux(4, 3, 8'hAA, 8'h0F, 8'hFF, 8'h00, 8'h5A, 1'b0);
        checkOutput("aux_add_cnt", aux_rcnt[0], 2);
        checkOutput("aux_max_cnt", aux_rcnt[2], 2);

        checkOutput("main_q_empty", main_q.size(), 0);
        checkOutput("aux_q_empty", aux_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
